// File: rtl/store_queue_if.sv
// store_queue_if: dispatch, AGU/DGU completion, commit, flush and drain
// signals of the store queue. The master modport is the core and memory side.
// The slave modport is the queue itself.
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 5
`endif

interface store_queue_if #(
    parameter int IDW = 4
);
    localparam int RW = `ROB_SIZE_LOG + 1;

    logic          disp_valid;
    logic [RW-1:0] disp_robid;
    logic          disp_ready;
    logic [IDW-1:0] disp_sqid;

    logic          st_agu_cmpl_valid;
    logic [IDW-1:0] st_agu_cmpl_sqid;
    logic          st_agu_cmpl_mmio;
    logic [63:0]   st_agu_cmpl_addr;
    logic [3:0]    st_agu_cmpl_size;
    logic [7:0]    st_agu_cmpl_mask;
    logic          st_dgu_cmpl_valid;
    logic [63:0]   st_dgu_cmpl_data;

    logic          commit_valid;
    logic          flush_valid;
    logic [RW-1:0] flush_robid;

    logic          dc_req_valid;
    logic [63:0]   dc_req_addr;
    logic [63:0]   dc_req_data;
    logic [7:0]    dc_req_mask;
    logic [3:0]    dc_req_size;
    logic          dc_req_mmio;
    logic          dc_req_ready;

    logic          sq_empty;

    modport master (
        output disp_valid, disp_robid,
        output st_agu_cmpl_valid, st_agu_cmpl_sqid, st_agu_cmpl_mmio,
        output st_agu_cmpl_addr, st_agu_cmpl_size, st_agu_cmpl_mask,
        output st_dgu_cmpl_valid, st_dgu_cmpl_data,
        output commit_valid, flush_valid, flush_robid, dc_req_ready,
        input  disp_ready, disp_sqid,
        input  dc_req_valid, dc_req_addr, dc_req_data, dc_req_mask,
        input  dc_req_size, dc_req_mmio, sq_empty
    );

    modport slave (
        input  disp_valid, disp_robid,
        input  st_agu_cmpl_valid, st_agu_cmpl_sqid, st_agu_cmpl_mmio,
        input  st_agu_cmpl_addr, st_agu_cmpl_size, st_agu_cmpl_mask,
        input  st_dgu_cmpl_valid, st_dgu_cmpl_data,
        input  commit_valid, flush_valid, flush_robid, dc_req_ready,
        output disp_ready, disp_sqid,
        output dc_req_valid, dc_req_addr, dc_req_data, dc_req_mask,
        output dc_req_size, dc_req_mmio, sq_empty
    );
endinterface

// File: rtl/store_queue.sv
// store_queue: in-order store queue with head, commit and tail pointers.
// Stores are allocated at dispatch and filled by the AGU/DGU. They are marked
// committed by the ROB, then drained from the head to the dcache/MMIO port.
// A flush kills uncommitted entries younger than the flush robid.
// Optional: define SQ_PERF_CNT_EN to add the sq_full_stall_cnt counter.
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 5
`endif

module store_queue #(
    parameter int DEPTH = 8,
    parameter int IDW   = 4
) (
    input  logic         clock,
    input  logic         reset,
    store_queue_if.slave sq
`ifdef SQ_PERF_CNT_EN
    ,
    output logic [31:0]  sq_full_stall_cnt
`endif
);
    localparam int IXW = $clog2(DEPTH);
    localparam int RW  = `ROB_SIZE_LOG + 1;

    typedef logic [IDW-1:0] ptr_t;

    ptr_t head, cmt, tail;

    logic [DEPTH-1:0]          valid, addr_ok, data_ok, committed;
    logic [DEPTH-1:0][RW-1:0]  robid;
    logic [DEPTH-1:0][63:0]    addr, data;
    logic [DEPTH-1:0][7:0]     mask;
    logic [DEPTH-1:0][3:0]     size;
    logic [DEPTH-1:0]          mmio;

    logic [IXW-1:0] hi, ci, ti, ai;
    logic full, empty, disp_fire, drain_fire, agu_ok, dgu_ok;
    logic [DEPTH-1:0] kill;
    logic kill_any;
    ptr_t kill_ptr, scan, p;

    // a is younger than b when exactly one of "wrap differs" and "idx greater" holds
    function automatic logic younger(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (a[RW-1] != b[RW-1]) ^ (a[RW-2:0] > b[RW-2:0]);
    endfunction

    assign hi = head[IXW-1:0];
    assign ci = cmt[IXW-1:0];
    assign ti = tail[IXW-1:0];
    assign ai = sq.st_agu_cmpl_sqid[IXW-1:0];

    assign full  = (hi == ti) && (head[IDW-1] != tail[IDW-1]);
    assign empty = (head == tail);

    // Dispatch sees only registered occupancy, so a same-cycle drain never frees a slot.
    assign sq.disp_ready = !full && !sq.flush_valid;
    assign sq.disp_sqid  = tail;
    assign sq.sq_empty   = empty;

    // The drain payload comes straight from the head entry registers.
    assign sq.dc_req_valid = valid[hi] && committed[hi];
    assign sq.dc_req_addr  = addr[hi];
    assign sq.dc_req_data  = data[hi];
    assign sq.dc_req_mask  = mask[hi];
    assign sq.dc_req_size  = size[hi];
    assign sq.dc_req_mmio  = mmio[hi];

    assign disp_fire  = sq.disp_valid && sq.disp_ready;
    assign drain_fire = sq.dc_req_valid && sq.dc_req_ready;
    assign agu_ok     = sq.st_agu_cmpl_valid && valid[ai] && !kill[ai];
    assign dgu_ok     = sq.st_dgu_cmpl_valid && valid[ai] && !kill[ai];

    // Flush kill scan runs over the uncommitted window [cmt, tail).
    // An entry committing this cycle is skipped, so committed or draining
    // stores are never killed. The descending loop leaves the oldest kill
    // in kill_ptr.
    always_comb begin
        kill     = '0;
        kill_any = 1'b0;
        kill_ptr = tail;
        p        = '0;
        scan     = cmt + ptr_t'(sq.commit_valid);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            p = scan + ptr_t'(k);
            if (sq.flush_valid && (ptr_t'(k) < (tail - scan)) &&
                valid[p[IXW-1:0]] && !committed[p[IXW-1:0]] &&
                younger(robid[p[IXW-1:0]], sq.flush_robid)) begin
                kill[p[IXW-1:0]] = 1'b1;
                kill_any         = 1'b1;
                kill_ptr         = p;
            end
        end
    end

    // This block holds the pointers and the per-entry status bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            head      <= '0;
            cmt       <= '0;
            tail      <= '0;
            valid     <= '0;
            addr_ok   <= '0;
            data_ok   <= '0;
            committed <= '0;
        end else begin
            if (disp_fire) begin
                valid[ti]     <= 1'b1;
                addr_ok[ti]   <= 1'b0;
                data_ok[ti]   <= 1'b0;
                committed[ti] <= 1'b0;
            end
            if (agu_ok)          addr_ok[ai]   <= 1'b1;
            if (dgu_ok)          data_ok[ai]   <= 1'b1;
            if (sq.commit_valid) committed[ci] <= 1'b1;
            if (drain_fire)      valid[hi]     <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                if (kill[i]) valid[i] <= 1'b0;

            if (sq.commit_valid) cmt  <= cmt + 1'b1;
            if (drain_fire)      head <= head + 1'b1;
            if (kill_any)        tail <= kill_ptr;
            else if (disp_fire)  tail <= tail + 1'b1;
        end
    end

    // Entry payload storage is not reset; each field is written only when its status bit is set.
    always_ff @(posedge clock) begin
        if (disp_fire) robid[ti] <= sq.disp_robid;
        if (agu_ok) begin
            addr[ai] <= sq.st_agu_cmpl_addr;
            size[ai] <= sq.st_agu_cmpl_size;
            mask[ai] <= sq.st_agu_cmpl_mask;
            mmio[ai] <= sq.st_agu_cmpl_mmio;
        end
        if (dgu_ok) data[ai] <= sq.st_dgu_cmpl_data;
    end

    // The ROB must never commit a store whose address or data is still missing.
    always_ff @(posedge clock) begin
        if (!reset && sq.commit_valid)
            assert (addr_ok[ci] && data_ok[ci])
            else $error("store_queue: commit on entry %0d without addr/data", ci);
    end

`ifdef SQ_PERF_CNT_EN
    // This counter counts dispatch attempts that stall on a full queue.
    // It saturates at all-ones.
    always_ff @(posedge clock) begin
        if (reset)
            sq_full_stall_cnt <= '0;
        else if (sq.disp_valid && full && (sq_full_stall_cnt != '1))
            sq_full_stall_cnt <= sq_full_stall_cnt + 1'b1;
    end
`endif

endmodule
